switch_conditioner: RTL and testbench
=====================================

# switch_conditioner

Input conditioning stage placed directly upstream of `clock`. It takes the three raw front-panel switches (`switch_1`..`switch_3`) and synchronises and debounces each one. It produces single-cycle press pulses with hold-to-auto-repeat, and these pulses drive the set/adjust inputs of `clock`. The three channels are identical and independent.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised input must disagree with the stable level before the level flips; must be ≥2.
- `HOLD_CYCLES`, default 16: cycles from the first press pulse to the first repeat pulse; must be ≥2.
- `REPEAT_CYCLES`, default 8: cycles between subsequent repeat pulses; must be ≥2.
- `REPEAT_EN`, default 1: when 0, a held switch produces exactly one pulse.
- `CNT_W`, default 16: counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) − 1.

Ports:
- `clk`  in  1  system clock; every register samples on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `switch_1`, `switch_2`, `switch_3`  in  1 each  raw asynchronous switch levels; 1 means pressed.
- `level_1`, `level_2`, `level_3`  out  1 each  debounced stable level; registered.
- `press_1`, `press_2`, `press_3`  out  1 each  one-cycle press/repeat pulse; registered.

## Operation
The following applies per channel.
- Synchroniser: two flops `sync0` → `sync1`, both reset to 0.
- Debounce:
  - Stable register `level` and counter `dcnt`, both reset to 0.
  - If `sync1 == level`, then `dcnt` ← 0.
  - Otherwise `dcnt` increments. On the edge where `dcnt == DEBOUNCE_CYCLES-1`, `level` ← `sync1` and `dcnt` ← 0.
  - Any agreement with `level` mid-count restarts the count, so bounce is rejected.
- Press FSM: states `SW_IDLE`, `SW_HOLD`, `SW_REPEAT`; reset state is `SW_IDLE`. Counter `rcnt` resets to 0.
  - `SW_IDLE`:
    - On a `level` rise (level=1 while the previous level was 0): `press` ← 1, `rcnt` ← 0, go to `SW_HOLD`.
  - `SW_HOLD`:
    - If `level`=0: go to `SW_IDLE`.
    - Else `rcnt` increments. At `rcnt == HOLD_CYCLES-1`: `press` ← 1, `rcnt` ← 0, and go to `SW_REPEAT` if `REPEAT_EN`, otherwise stay in `SW_HOLD` with no pulse and no further counting.
  - `SW_REPEAT`:
    - If `level`=0: go to `SW_IDLE`.
    - Else `rcnt` increments. At `rcnt == REPEAT_CYCLES-1`: `press` ← 1, `rcnt` ← 0.
  - `press` is 0 in every cycle not listed above.
- Counters never wrap, because they are cleared at their terminal count.
- Release never produces a pulse. A release followed by a re-press produces a fresh first pulse.
- Simultaneous activity on several channels produces independent, possibly coincident, pulses.
- Reset mid-operation:
  - All flops clear within that edge; outputs are 0 in the next cycle.
  - A switch held through reset release is treated as a new press, giving a first pulse at the normal latency.

## Timing
- Reset values: all `level_*` = 0, all `press_*` = 0.
- Let edge 0 be the first edge that samples the raw input at 1, with the input stable afterwards:
  - `sync1` = 1 after edge 1.
  - `level` = 1 after edge DEBOUNCE_CYCLES+1.
  - `press` is high for exactly the cycle after edge DEBOUNCE_CYCLES+2.
- Next pulse: HOLD_CYCLES edges later. Following pulses: every REPEAT_CYCLES edges.
- Release follows the same rule: `level` = 0 after edge R+DEBOUNCE_CYCLES+1, where R is the first edge sampling 0. The FSM returns to idle on the following edge.
- A raw pulse or glitch shorter than DEBOUNCE_CYCLES sampled cycles never changes `level` or `press`.

## Structure
- Shared package `clock_pkg` holds:
  - the FSM state enum (`SW_IDLE`, `SW_HOLD`, `SW_REPEAT`);
  - default constants for DEBOUNCE/HOLD/REPEAT cycles.
- Sub-module `switch_debounce` implements one channel: synchroniser, debounce, FSM and counters. It is instantiated three times by `switch_conditioner`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8, REPEAT_EN=1.
- Reset: assert `rst_n`=0 for 3 cycles with switches toggling → all `level_*` and `press_*` are 0 during reset and the cycle after.
- Clean short press: `switch_1` high for edges 0–9 → `level_1` rises after edge 5; exactly one `press_1` after edge 6; `level_1` falls after edge 15; no other pulses.
- Glitch rejection: `switch_2` high for 3 edges only → `level_2` and `press_2` remain 0 throughout.
- Bounce: `switch_3` alternates 1/0 each edge for 6 edges, then is stable high → exactly one `press_3`, 6 edges after the start of the stable level.
- Auto-repeat: `switch_1` high for edges 0–59 → `press_1` after edges 6, 22, 30, 38, 46, 54, 62 (7 pulses); none after edge 65. With REPEAT_EN=0 → a single pulse after edge 6.
- Concurrency and reset: `switch_1` and `switch_3` rise together → coincident pulses. Assert reset mid-hold with both switches still high → outputs clear; after release, a first pulse occurs again 6 edges after the first edge sampled out of reset.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared types and default constants for the clock front end.
//            Holds the per-switch press FSM state encoding and the default
//            debounce / hold / repeat timing used by switch_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Press FSM for one switch channel.
    typedef enum logic [1:0] {
        SW_IDLE   = 2'd0,
        SW_HOLD   = 2'd1,
        SW_REPEAT = 2'd2
    } sw_state_t;

    // Default timing, in clk cycles.
    localparam int c_default_debounce_cycles = 4;
    localparam int c_default_hold_cycles     = 16;
    localparam int c_default_repeat_cycles   = 8;
    localparam int c_default_cnt_w           = 16;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce
// Purpose  : One switch channel: two-flop synchroniser, counter-based
//            debounce and a press FSM that emits a single-cycle pulse on
//            press, then auto-repeat pulses while the switch stays held.
// Ports    : clk       - system clock, rising edge
//            rst_n     - synchronous active-low reset
//            i_switch  - raw asynchronous switch level (1 = pressed)
//            o_level   - debounced stable level (registered)
//            o_press   - one-cycle press / repeat pulse (registered)
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
    parameter int HOLD_CYCLES     = c_default_hold_cycles,
    parameter int REPEAT_CYCLES   = c_default_repeat_cycles,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_W           = c_default_cnt_w
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_switch,
    output logic o_level,
    output logic o_press
);

    // Terminal counts; counters clear on reaching these, so they never wrap.
    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rep_last  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_level_d;   // previous debounced level, for rise detect
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_rcnt;
    logic             r_press;
    sw_state_t        r_state;

    sw_state_t        w_state_next;
    logic [CNT_W-1:0] w_rcnt_next;
    logic             w_press_next;

    // Synchroniser and debounce. The level only flips after the synchronised
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive edges; any
    // agreement in between restarts the count, which rejects bounce.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_dcnt    <= '0;
        end else begin
            r_sync0   <= i_switch;
            r_sync1   <= r_sync0;
            r_level_d <= r_level;
            if (r_sync1 == r_level) begin
                r_dcnt <= '0;
            end else if (r_dcnt == c_deb_last) begin
                r_level <= r_sync1;
                r_dcnt  <= '0;
            end else begin
                r_dcnt <= r_dcnt + c_cnt_one;
            end
        end
    end

    // Press FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SW_IDLE;
            r_rcnt  <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rcnt  <= w_rcnt_next;
            r_press <= w_press_next;
        end
    end

    // Press FSM next-state / output logic.
    always_comb begin
        w_state_next = r_state;
        w_rcnt_next  = r_rcnt;
        w_press_next = 1'b0;
        case (r_state)
            SW_IDLE: begin
                if (r_level && !r_level_d) begin
                    w_press_next = 1'b1;
                    w_rcnt_next  = '0;
                    w_state_next = SW_HOLD;
                end
            end
            SW_HOLD: begin
                if (!r_level) begin
                    w_state_next = SW_IDLE;
                end else if (r_rcnt == c_hold_last) begin
                    // Without auto-repeat the counter parks at its terminal
                    // value: no pulse and no further counting until release.
                    if (REPEAT_EN) begin
                        w_press_next = 1'b1;
                        w_rcnt_next  = '0;
                        w_state_next = SW_REPEAT;
                    end
                end else begin
                    w_rcnt_next = r_rcnt + c_cnt_one;
                end
            end
            SW_REPEAT: begin
                if (!r_level) begin
                    w_state_next = SW_IDLE;
                end else if (r_rcnt == c_rep_last) begin
                    w_press_next = 1'b1;
                    w_rcnt_next  = '0;
                end else begin
                    w_rcnt_next = r_rcnt + c_cnt_one;
                end
            end
            default: begin
                w_state_next = SW_IDLE;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule : switch_debounce
`default_nettype wire

// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : switch_conditioner
// Purpose  : Conditions the three raw front-panel switches for the clock
//            block: each channel is synchronised, debounced and turned into
//            single-cycle press pulses with hold-to-auto-repeat. Channels are
//            identical and independent.
// Ports    : clk                  - system clock, rising edge
//            rst_n                - synchronous active-low reset
//            switch_1..switch_3   - raw asynchronous switch levels (1=pressed)
//            level_1..level_3     - debounced stable levels (registered)
//            press_1..press_3     - one-cycle press/repeat pulses (registered)
// Revision : 1.0 - initial release
// ============================================================================
module switch_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
    parameter int HOLD_CYCLES     = c_default_hold_cycles,
    parameter int REPEAT_CYCLES   = c_default_repeat_cycles,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_W           = c_default_cnt_w
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_1,
    input  logic switch_2,
    input  logic switch_3,
    output logic level_1,
    output logic level_2,
    output logic level_3,
    output logic press_1,
    output logic press_2,
    output logic press_3
);

    localparam int c_num_ch = 3;

    logic [c_num_ch-1:0] w_switch;
    logic [c_num_ch-1:0] w_level;
    logic [c_num_ch-1:0] w_press;

    assign w_switch = {switch_3, switch_2, switch_1};

    for (genvar gi = 0; gi < c_num_ch; gi++) begin : g_channel
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .CNT_W           (CNT_W)
        ) u_switch_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_switch (w_switch[gi]),
            .o_level  (w_level[gi]),
            .o_press  (w_press[gi])
        );
    end

    assign level_1 = w_level[0];
    assign level_2 = w_level[1];
    assign level_3 = w_level[2];
    assign press_1 = w_press[0];
    assign press_2 = w_press[1];
    assign press_3 = w_press[2];

endmodule : switch_conditioner
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_conditioner
// Purpose  : Self-checking bench for switch_conditioner. Two instances share
//            the switch inputs: one with auto-repeat, one without. Directed
//            scenarios use expected traces written from the timing rules;
//            a randomized run is checked against a trace-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_conditioner;

    localparam int D    = 4;
    localparam int H    = 16;
    localparam int R    = 8;
    localparam int MAXN = 640;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0;
    logic lv1, lv2, lv3, pr1, pr2, pr3;
    logic lvn1, lvn2, lvn3, prn1, prn2, prn3;

    always #5 clk = ~clk;

    switch_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
        .REPEAT_EN(1'b1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .switch_1(sw1), .switch_2(sw2), .switch_3(sw3),
        .level_1(lv1), .level_2(lv2), .level_3(lv3),
        .press_1(pr1), .press_2(pr2), .press_3(pr3)
    );

    switch_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
        .REPEAT_EN(1'b0), .CNT_W(16)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n),
        .switch_1(sw1), .switch_2(sw2), .switch_3(sw3),
        .level_1(lvn1), .level_2(lvn2), .level_3(lvn3),
        .press_1(prn1), .press_2(prn2), .press_3(prn3)
    );

    logic [2:0]  lv, pr, prn;
    logic [11:0] all_out;
    assign lv      = {lv3, lv2, lv1};
    assign pr      = {pr3, pr2, pr1};
    assign prn     = {prn3, prn2, prn1};
    assign all_out = {lv, pr, lvn3, lvn2, lvn1, prn};

    int n_checks = 0;
    int n_fails  = 0;

    bit raw_q        [3][MAXN];
    bit obs_level    [3][MAXN];
    bit obs_press    [3][MAXN];
    bit obs_press_nr [3][MAXN];
    bit exp_level    [3][MAXN];
    bit exp_press    [3][MAXN];
    bit exp_press_nr [3][MAXN];

    task automatic clear_all();
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < MAXN; k++) begin
                raw_q[ch][k]        = 1'b0;
                exp_level[ch][k]    = 1'b0;
                exp_press[ch][k]    = 1'b0;
                exp_press_nr[ch][k] = 1'b0;
            end
        end
    endtask

    // Called at a falling edge; leaves rst_n high at a falling edge so the
    // next rising edge is the first one sampled out of reset (edge 0).
    task automatic do_reset();
        rst_n = 1'b0;
        {sw3, sw2, sw1} = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives raw_q[.][k] into edge k and records the outputs after edge k.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            {sw3, sw2, sw1} = {raw_q[2][k], raw_q[1][k], raw_q[0][k]};
            @(posedge clk);
            @(negedge clk);
            for (int ch = 0; ch < 3; ch++) begin
                obs_level[ch][k]    = lv[ch];
                obs_press[ch][k]    = pr[ch];
                obs_press_nr[ch][k] = prn[ch];
            end
        end
    endtask

    // Value the debouncer compares at edge j: the raw sample two edges back
    // (both synchroniser flops start at 0 after reset).
    function automatic bit delayed_raw(input int ch, input int j);
        return (j >= 2) ? raw_q[ch][j-2] : 1'b0;
    endfunction

    // Trace-level model: the level flips at edge n when the compared input
    // disagreed with it on each of the last D edges, all after the previous
    // flip. Each rise yields a pulse the next edge, then one every H and R
    // edges while the level is still seen high.
    task automatic compute_model(input int n_edges);
        bit lvl;
        bit flip;
        int last_flip;
        int f;
        int p;
        for (int ch = 0; ch < 3; ch++) begin
            lvl = 1'b0;
            last_flip = -1000;
            for (int n = 0; n < n_edges; n++) begin
                flip = (n - last_flip >= D);
                for (int j = n - D + 1; j <= n; j++)
                    if (delayed_raw(ch, j) == lvl) flip = 1'b0;
                if (flip) begin
                    lvl = !lvl;
                    last_flip = n;
                end
                exp_level[ch][n]    = lvl;
                exp_press[ch][n]    = 1'b0;
                exp_press_nr[ch][n] = 1'b0;
            end
            for (int n = 1; n < n_edges; n++) begin
                if (exp_level[ch][n] && !exp_level[ch][n-1]) begin
                    f = n + 1;
                    while (f < n_edges && exp_level[ch][f]) f++;
                    p = n + 1;
                    if (p < n_edges) exp_press_nr[ch][p] = 1'b1;
                    while (p <= f && p < n_edges) begin
                        exp_press[ch][p] = 1'b1;
                        p += (p == n + 1) ? H : R;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            {sw3, sw2, sw1} = (k % 2 == 0) ? 3'b101 : 3'b010;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (all_out !== 12'b0) begin
                n_fails++;
                $display("FAIL reset_hold cycle %0d: outputs=%b expected all 0", k, all_out);
            end
        end
        rst_n = 1'b1;
        {sw3, sw2, sw1} = 3'b111;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (all_out !== 12'b0) begin
            n_fails++;
            $display("FAIL reset_after: outputs=%b expected all 0", all_out);
        end
    endtask

    task automatic test_short_press();
        clear_all();
        for (int k = 0; k < 10; k++) raw_q[0][k] = 1'b1;
        for (int k = 5; k < 15; k++) exp_level[0][k] = 1'b1;
        exp_press[0][6] = 1'b1;
        exp_press_nr[0][6] = 1'b1;
        do_reset();
        run_cycles(30);
        for (int k = 0; k < 30; k++) begin
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if ({obs_level[ch][k], obs_press[ch][k], obs_press_nr[ch][k]} !==
                    {exp_level[ch][k], exp_press[ch][k], exp_press_nr[ch][k]}) begin
                    n_fails++;
                    $display("FAIL short_press ch%0d edge %0d: level/press/press_norep=%b%b%b expected %b%b%b",
                             ch + 1, k, obs_level[ch][k], obs_press[ch][k], obs_press_nr[ch][k],
                             exp_level[ch][k], exp_press[ch][k], exp_press_nr[ch][k]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        clear_all();
        for (int k = 0; k < 3; k++) raw_q[1][k] = 1'b1;
        do_reset();
        run_cycles(20);
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if ({obs_level[1][k], obs_press[1][k], obs_press_nr[1][k]} !== 3'b000) begin
                n_fails++;
                $display("FAIL glitch ch2 edge %0d: level/press/press_norep=%b%b%b expected 000",
                         k, obs_level[1][k], obs_press[1][k], obs_press_nr[1][k]);
            end
        end
    endtask

    task automatic test_bounce();
        clear_all();
        for (int k = 0; k < 6; k++) raw_q[2][k] = (k % 2 == 0);
        for (int k = 6; k < 26; k++) raw_q[2][k] = 1'b1;
        // Stable high starts at edge 6: level after edge 11, pulse after 12.
        for (int k = 11; k < 26; k++) exp_level[2][k] = 1'b1;
        exp_press[2][12] = 1'b1;
        exp_press_nr[2][12] = 1'b1;
        do_reset();
        run_cycles(26);
        for (int k = 0; k < 26; k++) begin
            n_checks++;
            if ({obs_level[2][k], obs_press[2][k], obs_press_nr[2][k]} !==
                {exp_level[2][k], exp_press[2][k], exp_press_nr[2][k]}) begin
                n_fails++;
                $display("FAIL bounce ch3 edge %0d: level/press/press_norep=%b%b%b expected %b%b%b",
                         k, obs_level[2][k], obs_press[2][k], obs_press_nr[2][k],
                         exp_level[2][k], exp_press[2][k], exp_press_nr[2][k]);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int pulse_edges [7] = '{6, 22, 30, 38, 46, 54, 62};
        int n_pulses;
        clear_all();
        for (int k = 0; k < 60; k++) raw_q[0][k] = 1'b1;
        for (int k = 5; k < 65; k++) exp_level[0][k] = 1'b1;
        foreach (pulse_edges[i]) exp_press[0][pulse_edges[i]] = 1'b1;
        exp_press_nr[0][6] = 1'b1;
        do_reset();
        run_cycles(90);
        n_pulses = 0;
        for (int k = 0; k < 90; k++) begin
            if (obs_press[0][k]) n_pulses++;
            n_checks++;
            if ({obs_level[0][k], obs_press[0][k], obs_press_nr[0][k]} !==
                {exp_level[0][k], exp_press[0][k], exp_press_nr[0][k]}) begin
                n_fails++;
                $display("FAIL auto_repeat ch1 edge %0d: level/press/press_norep=%b%b%b expected %b%b%b",
                         k, obs_level[0][k], obs_press[0][k], obs_press_nr[0][k],
                         exp_level[0][k], exp_press[0][k], exp_press_nr[0][k]);
            end
        end
        n_checks++;
        if (n_pulses != 7) begin
            n_fails++;
            $display("FAIL auto_repeat_count: got %0d pulses expected 7", n_pulses);
        end
    endtask

    task automatic test_concurrency_reset();
        for (int pass = 0; pass < 2; pass++) begin
            clear_all();
            for (int k = 0; k < 12; k++) begin
                raw_q[0][k] = 1'b1;
                raw_q[2][k] = 1'b1;
            end
            if (pass == 0) do_reset();
            run_cycles(12);
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if ({obs_level[0][k], obs_level[2][k], obs_press[0][k], obs_press[2][k], obs_level[1][k]} !==
                    {k >= 5, k >= 5, k == 6, k == 6, 1'b0}) begin
                    n_fails++;
                    $display("FAIL concurrent pass%0d edge %0d: lvl1/lvl3/pr1/pr3/lvl2=%b%b%b%b%b expected %b%b%b%b0",
                             pass, k, obs_level[0][k], obs_level[2][k], obs_press[0][k], obs_press[2][k],
                             obs_level[1][k], k >= 5, k >= 5, k == 6, k == 6);
                end
            end
            if (pass == 0) begin
                // Reset mid-hold with both switches still pressed.
                rst_n = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    n_checks++;
                    if (all_out !== 12'b0) begin
                        n_fails++;
                        $display("FAIL midhold_reset cycle %0d: outputs=%b expected all 0", k, all_out);
                    end
                end
                rst_n = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        int k;
        int len;
        bit v;
        int n_pulses;
        for (int it = 0; it < 2; it++) begin
            clear_all();
            for (int ch = 0; ch < 3; ch++) begin
                k = 0;
                v = 1'($urandom_range(0, 1));
                while (k < 600) begin
                    len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D - 1)
                                                     : $urandom_range(D, 60);
                    for (int j = 0; j < len && k < 600; j++) begin
                        raw_q[ch][k] = v;
                        k++;
                    end
                    v = !v;
                end
            end
            do_reset();
            run_cycles(600);
            compute_model(600);
            n_pulses = 0;
            for (int n = 0; n < 600; n++) begin
                for (int ch = 0; ch < 3; ch++) begin
                    if (exp_press[ch][n]) n_pulses++;
                    n_checks++;
                    if ({obs_level[ch][n], obs_press[ch][n], obs_press_nr[ch][n]} !==
                        {exp_level[ch][n], exp_press[ch][n], exp_press_nr[ch][n]}) begin
                        n_fails++;
                        $display("FAIL random it%0d ch%0d edge %0d: level/press/press_norep=%b%b%b expected %b%b%b",
                                 it, ch + 1, n, obs_level[ch][n], obs_press[ch][n], obs_press_nr[ch][n],
                                 exp_level[ch][n], exp_press[ch][n], exp_press_nr[ch][n]);
                    end
                end
            end
            n_checks++;
            if (n_pulses == 0) begin
                n_fails++;
                $display("FAIL random_activity it%0d: model produced %0d pulses expected >0", it, n_pulses);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_short_press();
        test_glitch();
        test_bounce();
        test_auto_repeat();
        test_concurrency_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_switch_conditioner
`default_nettype wire
